hilo_muldiv_unit: RTL



---
 rtl/hilo_muldiv_unit.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: owns the MIPS HI/LO registers and runs MULT/MULTU/DIV/DIVU
// as a 32-iteration shift-add / restoring-division sequence (33 cycles busy),
// plus single-cycle MTHI/MTLO writes.
// Optional feature macro: HILO_FAST_MULT_EN -- when defined, MULT/MULTU use a
// single-cycle 64-bit multiplier and never raise busy; DIV/DIVU are unchanged.
module hilo_muldiv_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX} state_t;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   // MUL: op_a = shifting multiplicand, op_b = multiplier, acc = product.
   // DIV: op_a[31:0] = divisor, op_b = dividend shifting into quotient,
   //      acc[32:0] = partial remainder.
   logic [63:0] op_a_q, op_a_d;
   logic [31:0] op_b_q, op_b_d;
   logic [63:0] acc_q, acc_d;
   logic        res_neg_q, res_neg_d;
   logic        dvd_neg_q, dvd_neg_d;
   logic        is_div_q, is_div_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic        op_signed;
   logic [31:0] rs_mag, rt_mag;
   logic [32:0] rem_shift;
   logic [33:0] rem_diff;
   logic [63:0] prod_fix;
`ifdef HILO_FAST_MULT_EN
   logic [63:0] fast_prod;
`endif

   // Operand magnitudes for the signed ops; unsigned ops pass raw operands.
   always_comb begin
      op_signed = (op == OP_MULT) || (op == OP_DIV);
      rs_mag    = (op_signed && rs_val[31]) ? (32'd0 - rs_val) : rs_val;
      rt_mag    = (op_signed && rt_val[31]) ? (32'd0 - rt_val) : rt_val;
`ifdef HILO_FAST_MULT_EN
      fast_prod = {32'd0, rs_mag} * {32'd0, rt_mag};
      if (op_signed && (rs_val[31] ^ rt_val[31]))
         fast_prod = 64'd0 - fast_prod;
`endif
   end

   // Restoring-division step and final product sign correction.
   always_comb begin
      rem_shift = {acc_q[31:0], op_b_q[31]};
      rem_diff  = {1'b0, rem_shift} - {2'b00, op_a_q[31:0]};
      prod_fix  = res_neg_q ? (64'd0 - acc_q) : acc_q;
   end

   // Next-state logic for the sequencer and the architectural HI/LO.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_a_d    = op_a_q;
      op_b_d    = op_b_q;
      acc_d     = acc_q;
      res_neg_d = res_neg_q;
      dvd_neg_d = dvd_neg_q;
      is_div_d  = is_div_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      hi_d      = hi_q;
      lo_d      = lo_q;
      case (state_q)
         ST_IDLE: begin
            if (start && !busy_q) begin
               case (op)
                  OP_MULT, OP_MULTU: begin
`ifdef HILO_FAST_MULT_EN
                     hi_d   = fast_prod[63:32];
                     lo_d   = fast_prod[31:0];
                     done_d = 1'b1;
`else
                     op_a_d    = {32'd0, rs_mag};
                     op_b_d    = rt_mag;
                     acc_d     = 64'd0;
                     res_neg_d = op_signed && (rs_val[31] ^ rt_val[31]);
                     dvd_neg_d = 1'b0;
                     is_div_d  = 1'b0;
                     cnt_d     = 5'd0;
                     busy_d    = 1'b1;
                     state_d   = ST_MUL;
`endif
                  end
                  OP_DIV, OP_DIVU: begin
                     op_a_d    = {32'd0, rt_mag};
                     op_b_d    = rs_mag;
                     acc_d     = 64'd0;
                     // A zero divisor must leave the all-ones quotient
                     // un-negated; the remainder path then restores rs_val.
                     res_neg_d = op_signed && (rs_val[31] ^ rt_val[31]) && (rt_val != 32'd0);
                     dvd_neg_d = op_signed && rs_val[31];
                     is_div_d  = 1'b1;
                     cnt_d     = 5'd0;
                     busy_d    = 1'b1;
                     state_d   = ST_DIV;
                  end
                  OP_MTHI: hi_d = rs_val;
                  OP_MTLO: lo_d = rs_val;
                  default: ;
               endcase
            end
         end
         ST_MUL: begin
            if (op_b_q[0])
               acc_d = acc_q + op_a_q;
            op_a_d = {op_a_q[62:0], 1'b0};
            op_b_d = {1'b0, op_b_q[31:1]};
            cnt_d  = cnt_q + 5'd1;
            if (cnt_q == 5'd31)
               state_d = ST_FIX;
         end
         ST_DIV: begin
            if (!rem_diff[33]) begin
               acc_d  = {31'd0, rem_diff[32:0]};
               op_b_d = {op_b_q[30:0], 1'b1};
            end else begin
               acc_d  = {31'd0, rem_shift};
               op_b_d = {op_b_q[30:0], 1'b0};
            end
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31)
               state_d = ST_FIX;
         end
         ST_FIX: begin
            if (is_div_q) begin
               lo_d = res_neg_q ? (32'd0 - op_b_q) : op_b_q;
               hi_d = dvd_neg_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
            end else begin
               hi_d = prod_fix[63:32];
               lo_d = prod_fix[31:0];
            end
            busy_d  = 1'b0;
            done_d  = 1'b1;
            cnt_d   = 5'd0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers; reset aborts any operation in progress.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 5'd0;
         op_a_q    <= 64'd0;
         op_b_q    <= 32'd0;
         acc_q     <= 64'd0;
         res_neg_q <= 1'b0;
         dvd_neg_q <= 1'b0;
         is_div_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_a_q    <= op_a_d;
         op_b_q    <= op_b_d;
         acc_q     <= acc_d;
         res_neg_q <= res_neg_d;
         dvd_neg_q <= dvd_neg_d;
         is_div_q  <= is_div_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule
